// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the write-back source sequencer: data-source codes,
// FSM state encoding and source classification helpers.
package wb_ctrl_pkg;

  localparam int unsigned SRC_ALUOUT  = 0;
  localparam int unsigned SRC_SLS     = 1;
  localparam int unsigned SRC_LO      = 2;
  localparam int unsigned SRC_HI      = 3;
  localparam int unsigned SRC_SHIFT   = 4;
  localparam int unsigned SRC_LT      = 5;
  localparam int unsigned SRC_SIGNEXT = 6;
  localparam int unsigned SRC_SHL16   = 7;
  localparam int unsigned SRC_REGA    = 8;
  localparam int unsigned SRC_REGB    = 9;
  localparam int unsigned SRC_LAST    = SRC_REGB;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWaitMd = 3'd1,
    StSetup  = 3'd2,
    StWrite  = 3'd3,
    StErr    = 3'd4
  } wb_state_e;

  // HI/LO are the only sources produced by the mult/div unit.
  function automatic logic is_hilo(input int unsigned src);
    return (src == SRC_HI) || (src == SRC_LO);
  endfunction

  function automatic logic is_legal(input int unsigned src);
    return src <= SRC_LAST;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Wait-cycle counter for the mult/div stall; flags the last permitted cycle.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TermCnt);

endmodule

// File: rtl/wb_source_ctrl.sv
// Write-back sequencer: latches a source/destination request, stalls on busy
// HI/LO, lets the data-source mux settle for a cycle, then commits one write.
module wb_source_ctrl
  import wb_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned SRC_W          = 4,
  parameter int unsigned REG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SRC_W-1:0] src_sel,
  input  logic [REG_W-1:0] dst_reg,
  input  logic             md_busy,
  input  logic             flush,
  output logic [SRC_W-1:0] mux_dataSource_control,
  output logic             reg_write,
  output logic [REG_W-1:0] reg_addr,
  output logic             busy,
  output logic             done,
  output logic             error
);

  wb_state_e        state_q, state_d;
  logic [SRC_W-1:0] src_q;
  logic [REG_W-1:0] dst_q;
  logic             latch;
  logic             cnt_clear;
  logic             cnt_enable;
  logic             cnt_tc;
  int unsigned      src_val;

  assign src_val = 32'(src_sel);

  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .enable(cnt_enable),
    .tc    (cnt_tc)
  );

  always_comb begin
    state_d    = state_q;
    latch      = 1'b0;
    cnt_clear  = 1'b1;
    cnt_enable = 1'b0;
    unique case (state_q)
      StIdle: begin
        // flush squashes a request arriving in the same cycle
        if (start && !flush) begin
          latch = 1'b1;
          if (!is_legal(src_val)) begin
            state_d = StErr;
          end else if (is_hilo(src_val) && md_busy) begin
            state_d = StWaitMd;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StWaitMd: begin
        cnt_enable = 1'b1;
        cnt_clear  = 1'b0;
        if (flush) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end else if (!md_busy) begin
          state_d   = StSetup;
          cnt_clear = 1'b1;
        end else if (cnt_tc) begin
          state_d   = StErr;
          cnt_clear = 1'b1;
        end
      end
      StSetup: state_d = flush ? StIdle : StWrite;
      StWrite: state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        src_q <= src_sel;
        dst_q <= dst_reg;
      end
    end
  end

  always_comb begin
    mux_dataSource_control = src_q;
    reg_addr               = dst_q;
    busy                   = (state_q != StIdle);
    done                   = (state_q == StWrite) || (state_q == StErr);
    error                  = (state_q == StErr);
    // register $0 is hard-wired, so its write is dropped but still completes
    reg_write              = (state_q == StWrite) && (dst_q != '0);
  end

endmodule

// File: tb/tb_wb_source_ctrl.sv
// Scoreboard bench: two sequencers (long and short timeout) share stimulus;
// each done pulse is checked against hand-computed expectations.
module tb_wb_source_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, md_busy, flush;
  logic [3:0] src_sel;
  logic [4:0] dst_reg;

  logic [3:0] mux [2];
  logic [4:0] ra  [2];
  logic       rw  [2];
  logic       bsy [2];
  logic       dn  [2];
  logic       er  [2];

  always #5 clk = ~clk;

  wb_source_ctrl #(.TIMEOUT_CYCLES(64), .SRC_W(4), .REG_W(5)) dut_long (
    .clk(clk), .reset(reset), .start(start), .src_sel(src_sel), .dst_reg(dst_reg),
    .md_busy(md_busy), .flush(flush), .mux_dataSource_control(mux[0]),
    .reg_write(rw[0]), .reg_addr(ra[0]), .busy(bsy[0]), .done(dn[0]), .error(er[0])
  );

  wb_source_ctrl #(.TIMEOUT_CYCLES(4), .SRC_W(4), .REG_W(5)) dut_short (
    .clk(clk), .reset(reset), .start(start), .src_sel(src_sel), .dst_reg(dst_reg),
    .md_busy(md_busy), .flush(flush), .mux_dataSource_control(mux[1]),
    .reg_write(rw[1]), .reg_addr(ra[1]), .busy(bsy[1]), .done(dn[1]), .error(er[1])
  );

  typedef struct {
    int         cyc;
    logic [3:0] mux;
    logic       we;
    logic [4:0] addr;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int which, input int off, input logic [3:0] m, input logic we,
                      input logic [4:0] a, input logic err);
    exp_t e;
    e.cyc = s + off; e.mux = m; e.we = we; e.addr = a; e.err = err;
    if (which != 1) q0.push_back(e);
    if (which != 0) q1.push_back(e);
  endtask

  task automatic cmp_entry(input int i, input exp_t e);
    check($sformatf("done_cycle%0d", i), cyc, e.cyc);
    check($sformatf("mux%0d", i), mux[i], e.mux);
    check($sformatf("reg_write%0d", i), rw[i], e.we);
    check($sformatf("reg_addr%0d", i), ra[i], e.addr);
    check($sformatf("error%0d", i), er[i], e.err);
  endtask

  task automatic check_idle(input string name);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_busy%0d", name, i), bsy[i], 0);
      check($sformatf("%s_done%0d", name, i), dn[i], 0);
    end
  endtask

  // Monitor: every done pulse must match the head of its instance's queue.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("write_gated%0d", i), rw[i] & ~dn[i], 0);
        if (dn[i]) begin
          if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("unexpected_done%0d", i), 1, 0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            cmp_entry(i, e);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; md_busy = 1'b0;
    src_sel = '0; dst_reg = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_mux%0d", i), mux[i], 0);
      check($sformatf("rst_addr%0d", i), ra[i], 0);
      check($sformatf("rst_we%0d", i), rw[i], 0);
      check($sformatf("rst_err%0d", i), er[i], 0);
    end
    check_idle("rst");
    reset = 1'b0;

    // Plain ALUOut write to r8
    @(negedge clk); s = cyc;
    start = 1'b1; src_sel = 4'd0; dst_reg = 5'd8; push(2, 2, 4'd0, 1, 5'd8, 0);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 2; i++) check($sformatf("t1_busy_k1_%0d", i), bsy[i], 1);
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("t1_busy_k2_%0d", i), bsy[i], 1);
    @(negedge clk); check_idle("t1_after");

    // LO with 5-cycle stall: long instance writes, short instance times out
    md_busy = 1'b1; s = cyc;
    start = 1'b1; src_sel = 4'd2; dst_reg = 5'd9;
    push(0, 7, 4'd2, 1, 5'd9, 0); push(1, 5, 4'd2, 0, 5'd9, 1);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    md_busy = 1'b0;
    repeat (4) @(negedge clk);

    // HI held busy: short instance errors after 4 waits, long one writes later
    md_busy = 1'b1; s = cyc;
    start = 1'b1; src_sel = 4'd3; dst_reg = 5'd17;
    push(0, 8, 4'd3, 1, 5'd17, 0); push(1, 5, 4'd3, 0, 5'd17, 1);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    md_busy = 1'b0;
    repeat (5) @(negedge clk);

    // Illegal source 12
    s = cyc; start = 1'b1; src_sel = 4'd12; dst_reg = 5'd3;
    push(2, 1, 4'd12, 0, 5'd3, 1);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);

    // LT to $0, md_busy high but irrelevant for this source
    md_busy = 1'b1; s = cyc; start = 1'b1; src_sel = 4'd5; dst_reg = 5'd0;
    push(2, 2, 4'd5, 0, 5'd0, 0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    md_busy = 1'b0;

    // Extra start pulses while busy are dropped
    s = cyc; start = 1'b1; src_sel = 4'd0; dst_reg = 5'd5;
    push(2, 2, 4'd0, 1, 5'd5, 0);
    @(negedge clk); src_sel = 4'd9; dst_reg = 5'd6;
    @(negedge clk);
    @(negedge clk); start = 1'b0;
    check_idle("t6_after");
    repeat (3) @(negedge clk);

    // Flush during SETUP aborts silently
    start = 1'b1; src_sel = 4'd1; dst_reg = 5'd4;
    @(negedge clk); start = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check_idle("flush_setup");
    check("flush_setup_mux", mux[0], 4'd1);
    repeat (2) @(negedge clk);

    // Flush with start in IDLE drops the request
    start = 1'b1; flush = 1'b1; src_sel = 4'd0; dst_reg = 5'd7;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    check_idle("flush_idle");
    repeat (3) @(negedge clk);

    // Flush in WRITE has no effect
    s = cyc; start = 1'b1; src_sel = 4'd8; dst_reg = 5'd10;
    push(2, 2, 4'd8, 1, 5'd10, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (2) @(negedge clk);

    // Reset while stalled in WAIT_MD
    md_busy = 1'b1; start = 1'b1; src_sel = 4'd3; dst_reg = 5'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_wait_mux%0d", i), mux[i], 0);
      check($sformatf("rst_wait_addr%0d", i), ra[i], 0);
      check($sformatf("rst_wait_we%0d", i), rw[i], 0);
      check($sformatf("rst_wait_err%0d", i), er[i], 0);
    end
    check_idle("rst_wait");
    reset = 1'b0; md_busy = 1'b0;
    repeat (4) @(negedge clk);

    check("pending_long", q0.size(), 0);
    check("pending_short", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
